// File: rtl/gray_decoder_capture.sv
// Gray-code capture stage: waits for a stable synchronized Gray word, converts it
// to binary and registers it with a one-cycle bin_valid pulse. Optional macro:
// GRAY_STEP_CHECK_EN enables the sticky step_err multi-bit-step detector.
module gray_decoder_capture #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic             read,
  input  logic [WIDTH-1:0] Gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_err,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_CYCLES - 1);
  localparam logic [1:0]    FIRST_NEXT = (STABLE_CYCLES == 1) ? UPDATE : SETTLE;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] last_gray;

  // Handshake: there is no backpressure; bin_valid is a single-cycle strobe that
  // qualifies bin_out in the cycle it rises, and read gates whether new words are
  // considered at all.

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

`ifdef GRAY_STEP_CHECK_EN
  function automatic logic multi_bit(input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) n = n + int'(d[i]);
    return (n > 1);
  endfunction
`endif

  always_ff @(posedge reloj) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      last_gray <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
`ifdef GRAY_STEP_CHECK_EN
      step_err  <= 1'b0;
`endif
    end else begin
      bin_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (read && (Gray_in != last_gray)) begin
            cand  <= Gray_in;
            cnt   <= CW'(1);
            state <= FIRST_NEXT;
          end
        end
        SETTLE: begin
          // A word that falls back to the committed value is treated as a glitch.
          if (!read) begin
            state <= IDLE;
          end else if (Gray_in == last_gray) begin
            state <= IDLE;
          end else if (Gray_in != cand) begin
            cand <= Gray_in;
            cnt  <= CW'(1);
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) state <= UPDATE;
          end
        end
        UPDATE: begin
          bin_out   <= gray2bin(cand);
          last_gray <= cand;
          bin_valid <= 1'b1;
          state     <= IDLE;
`ifdef GRAY_STEP_CHECK_EN
          if (multi_bit(cand ^ last_gray)) step_err <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef GRAY_STEP_CHECK_EN
  assign step_err = 1'b0;
`endif

  assign dbg_state = state;

endmodule
